sine_dds: RTL

- Direct digital synthesis source that feeds the 12-bit DAC stage.
- Produces offset-binary sine samples, one per `en` tick. `en` is the same TickCounter strobe that clocks the DAC.
- Phase accumulator plus quarter-wave ROM with symmetry folding.
- Frequency word changes are staged and applied only at a phase wrap, so frequency switches are glitch-free.

---
 rtl/sine_pkg.sv | 35 +++
 rtl/sine_quarter_rom.sv | 28 ++
 rtl/sine_dds.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sine_pkg.sv
// Shared constants for the sine DDS: widths, quadrant encoding and the
// quarter-wave table definition used by both the ROM and its reference model.
package sine_pkg;

  localparam int DATA_W   = 12;
  localparam int MIDSCALE = 2048;

  localparam real PI = 3.14159265358979323846;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quadrant_e;

  // Entry k = round((2^(data_w-1) - 0.5) * sin(2*pi*(k+0.5) / (4*2^addr_w))).
  // The half-sample offset makes index inversion an exact mirror.
  function automatic int quarter_sine(input int k, input int addr_w, input int data_w);
    real amp;
    real ang;
    amp = real'(2 ** (data_w - 1)) - 0.5;
    ang = 2.0 * PI * (real'(k) + 0.5) / (4.0 * real'(2 ** addr_w));
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

  function automatic logic is_mirrored(input quadrant_e q);
    return (q == QUAD_1) || (q == QUAD_3);
  endfunction

  function automatic logic is_negative(input quadrant_e q);
    return (q == QUAD_2) || (q == QUAD_3);
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Registered quarter-wave sine ROM; contents come from sine_pkg::quarter_sine
// so the table has a single definition.
module sine_quarter_rom #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-2:0] o_data
);
  import sine_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-2:0] w_table [DEPTH];
  logic [DATA_W-2:0] r_data;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_table
    assign w_table[gi] = (DATA_W-1)'(quarter_sine(gi, ADDR_W, DATA_W));
  end

  always_ff @(posedge clk) begin
    r_data <= w_table[i_addr];
  end

  assign o_data = r_data;

endmodule

// File: rtl/sine_dds.sv
// Sine DDS: phase accumulator, wrap-synchronised frequency staging and a
// 3-stage quarter-wave lookup pipeline producing offset-binary samples.
module sine_dds #(
  parameter int PHASE_W = 16,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = sine_pkg::DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] fcw,
  input  logic               fcw_wr,
  output logic               fcw_pending,
  output logic [DATA_W-1:0]  data_out,
  output logic               valid,
  output logic               phase_wrap
);
  import sine_pkg::*;

  localparam logic [DATA_W-1:0] MID_CODE = DATA_W'(2 ** (DATA_W - 1));

  logic [PHASE_W-1:0] r_acc;
  logic [PHASE_W-1:0] r_fcw_active;
  logic [PHASE_W-1:0] r_staging;
  logic               r_pending;
  logic               r_phase_wrap;

  logic               r_s0_valid;
  quadrant_e          r_s0_quad;
  logic [ADDR_W-1:0]  r_s0_addr;
  logic               r_s1_valid;
  quadrant_e          r_s1_quad;
  logic [DATA_W-1:0]  r_data_out;
  logic               r_valid;

  logic [PHASE_W:0]   w_sum;
  logic               w_carry;
  logic               w_apply;
  quadrant_e          w_quad;
  logic [ADDR_W-1:0]  w_idx;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-2:0]  w_rom_data;
  logic [DATA_W-1:0]  w_fold;

  assign w_sum   = {1'b0, r_acc} + {1'b0, r_fcw_active};
  assign w_carry = w_sum[PHASE_W];

  // A stopped accumulator never wraps, so a staged word applies immediately.
  assign w_apply = r_pending && ((en && w_carry) || (r_fcw_active == '0));

  assign w_quad = quadrant_e'(r_acc[PHASE_W-1 -: 2]);
  assign w_idx  = r_acc[PHASE_W-3 -: ADDR_W];
  assign w_addr = is_mirrored(w_quad) ? ~w_idx : w_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc        <= '0;
      r_fcw_active <= '0;
      r_staging    <= '0;
      r_pending    <= 1'b0;
      r_phase_wrap <= 1'b0;
    end else begin
      if (en) begin
        r_acc <= w_sum[PHASE_W-1:0];
      end
      r_phase_wrap <= en && w_carry;
      if (w_apply) begin
        r_fcw_active <= r_staging;
      end
      // A write coinciding with an application re-arms pending for the new word.
      if (fcw_wr) begin
        r_staging <= fcw;
        r_pending <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_valid <= 1'b0;
      r_s0_quad  <= QUAD_0;
      r_s0_addr  <= '0;
      r_s1_valid <= 1'b0;
      r_s1_quad  <= QUAD_0;
      r_data_out <= MID_CODE;
      r_valid    <= 1'b0;
    end else begin
      r_s0_valid <= en;
      if (en) begin
        r_s0_quad <= w_quad;
        r_s0_addr <= w_addr;
      end
      r_s1_valid <= r_s0_valid;
      r_s1_quad  <= r_s0_quad;
      r_valid    <= r_s1_valid;
      if (r_s1_valid) begin
        r_data_out <= w_fold;
      end
    end
  end

  sine_quarter_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rom (
    .clk    (clk),
    .i_addr (r_s0_addr),
    .o_data (w_rom_data)
  );

  // Positive half sits above midscale, negative half mirrors just below it.
  always_comb begin
    w_fold = MID_CODE;
    if (is_negative(r_s1_quad)) begin
      w_fold = MID_CODE - DATA_W'(1) - DATA_W'(w_rom_data);
    end else begin
      w_fold = MID_CODE + DATA_W'(w_rom_data);
    end
  end

  assign fcw_pending = r_pending;
  assign data_out    = r_data_out;
  assign valid       = r_valid;
  assign phase_wrap  = r_phase_wrap;

endmodule
